// File: rtl/scan_ctrl_if.sv
// Host/DUT-side bundle for scan_ctrl: op request, dump read stream, load write stream and scan pins.
//   op_*    : operation request handshake (op_load_i selects DUMP=0 / LOAD=1)
//   rd_*    : dump words towards the host
//   wr_*    : load words from the host
//   scan_*  : scan chain control and data, dut_run_o freezes the instrumented DUT
//   busy_o / done_o : operation status
// The slave modport is the controller; master is the host/DUT side.
interface scan_ctrl_if #(
  parameter int unsigned WORD_W = 32
);
  logic              op_valid_i;
  logic              op_ready_o;
  logic              op_load_i;
  logic              dut_run_o;
  logic              scan_en_o;
  logic              scan_in_o;
  logic              scan_out_i;
  logic [WORD_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic [WORD_W-1:0] wr_data_i;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  op_valid_i, op_load_i, scan_out_i, rd_ready_i, wr_data_i, wr_valid_i,
    output op_ready_o, dut_run_o, scan_en_o, scan_in_o, rd_data_o, rd_valid_o,
           wr_ready_o, busy_o, done_o
  );

  modport master (
    output op_valid_i, op_load_i, scan_out_i, rd_ready_i, wr_data_i, wr_valid_i,
    input  op_ready_o, dut_run_o, scan_en_o, scan_in_o, rd_data_o, rd_valid_o,
           wr_ready_o, busy_o, done_o
  );
endinterface

// File: rtl/scan_ctrl.sv
// Scan chain controller for the instrumented DUT.
//   DUMP freezes the DUT and streams the chain out as WORD_W-bit words while looping the
//   chain back on itself, so the DUT state is unchanged afterwards.
//   LOAD takes words from the host and shifts them in; the first bit shifted ends at the tail.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : scan_ctrl_if.slave (op request, rd/wr word streams, scan pins, status)
module scan_ctrl #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned WORD_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  scan_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    D_SHIFT,
    D_EMIT,
    L_FETCH,
    L_SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bidx;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] dump_word;
  logic [CW-1:0]     cnt_inc;
  logic              last_bit;
  logic              word_end;

  // Word being assembled with the current tail bit dropped into its slot.
  always_comb begin
    dump_word       = word_q;
    dump_word[bidx] = bus.scan_out_i;
  end

  assign cnt_inc  = cnt + CW'(1);
  assign last_bit = (cnt_inc == CW'(CHAIN_LEN));
  assign word_end = (bidx == BW'(WORD_W - 1));

  // Loopback keeps the chain intact during DUMP; LOAD feeds the buffer LSB first.
  assign bus.scan_in_o = (state == D_SHIFT) ? bus.scan_out_i :
                         (state == L_SHIFT) ? word_q[0]      : 1'b0;

  // Control FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bidx           <= '0;
      word_q         <= '0;
      bus.op_ready_o <= 1'b1;
      bus.dut_run_o  <= 1'b1;
      bus.scan_en_o  <= 1'b0;
      bus.rd_data_o  <= '0;
      bus.rd_valid_o <= 1'b0;
      bus.wr_ready_o <= 1'b0;
      bus.busy_o     <= 1'b0;
      bus.done_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid_i && bus.op_ready_o) begin
            bus.op_ready_o <= 1'b0;
            bus.busy_o     <= 1'b1;
            bus.dut_run_o  <= 1'b0;
            cnt            <= '0;
            bidx           <= '0;
            word_q         <= '0;
            if (bus.op_load_i) begin
              state          <= L_FETCH;
              bus.wr_ready_o <= 1'b1;
            end else begin
              state         <= D_SHIFT;
              bus.scan_en_o <= 1'b1;
            end
          end
        end

        D_SHIFT: begin
          word_q <= dump_word;
          cnt    <= cnt_inc;
          bidx   <= bidx + BW'(1);
          if (word_end || last_bit) begin
            state          <= D_EMIT;
            bus.scan_en_o  <= 1'b0;
            bus.rd_valid_o <= 1'b1;
            bus.rd_data_o  <= dump_word;
          end
        end

        // Hold the word until the host takes it; the chain does not move meanwhile.
        D_EMIT: begin
          if (bus.rd_ready_i) begin
            bus.rd_valid_o <= 1'b0;
            if (cnt == CW'(CHAIN_LEN)) begin
              state      <= DONE;
              bus.done_o <= 1'b1;
            end else begin
              state         <= D_SHIFT;
              bus.scan_en_o <= 1'b1;
              word_q        <= '0;
              bidx          <= '0;
            end
          end
        end

        L_FETCH: begin
          if (bus.wr_valid_i) begin
            state          <= L_SHIFT;
            bus.wr_ready_o <= 1'b0;
            bus.scan_en_o  <= 1'b1;
            word_q         <= bus.wr_data_i;
            bidx           <= '0;
          end
        end

        // Surplus bits of the last word are simply never shifted.
        L_SHIFT: begin
          word_q <= word_q >> 1;
          cnt    <= cnt_inc;
          bidx   <= bidx + BW'(1);
          if (word_end || last_bit) begin
            bus.scan_en_o <= 1'b0;
            if (last_bit) begin
              state      <= DONE;
              bus.done_o <= 1'b1;
            end else begin
              state          <= L_FETCH;
              bus.wr_ready_o <= 1'b1;
            end
          end
        end

        DONE: begin
          state          <= IDLE;
          bus.done_o     <= 1'b0;
          bus.dut_run_o  <= 1'b1;
          bus.op_ready_o <= 1'b1;
          bus.busy_o     <= 1'b0;
          bidx           <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
